reservation_station: RTL and testbench
======================================

// Module: reservation_station
// PURPOSE
//  Holds decoded ALU-class instructions (arith, branch, LUI/AUIPC, JAL/JALR) until both operands are available.
//  Snoops the ALU and LSB result broadcasts to wake up waiting operands.
//  Each cycle, issues at most one ready entry to the combinational ALU on the rs_to_alu_* bus.
//  Sits between the decoder/dispatch stage and the ALU.
// PARAMETERS
//  RS_SIZE    16  number of entries (power of 2)
//  ROB_WIDTH   4  width of ROB index / rename tag
//  OP_WIDTH    6  width of opcode enum (`OPENUM_TYPE)
//  XLEN       32  data/address width
// PORTS
//  clk_in           in   1          clock
//  rst_in           in   1          synchronous reset, active-high
//  rdy_in           in   1          global enable; low = freeze all state
//  clr_in           in   1          flush on misprediction
//  issue_valid      in   1          dispatcher writes one entry this cycle
//  issue_op         in   OP_WIDTH   opcode enum
//  issue_vj/vk      in   XLEN       operand values (valid when pending bit low)
//  issue_qj_pend    in   1          rs1 waits on tag issue_qj
//  issue_qk_pend    in   1          rs2 waits on tag issue_qk
//  issue_qj/qk      in   ROB_WIDTH  producer ROB tags
//  issue_rob_index  in   ROB_WIDTH  destination ROB entry
//  issue_pc         in   XLEN       instruction PC
//  issue_imm        in   XLEN       sign-extended immediate
//  rs_full          out  1          all entries busy
//  alu_ready        in   1          ALU broadcast valid
//  alu_result       in   XLEN       ALU result
//  alu_rob_index    in   ROB_WIDTH  ALU result tag
//  lsb_ready        in   1          LSB broadcast valid
//  lsb_result       in   XLEN       LSB result
//  lsb_rob_index    in   ROB_WIDTH  LSB result tag
//  rs_to_alu_ready  out  1          registered issue valid
//  rs_to_alu_op     out  OP_WIDTH   registered issue fields
//  rs_to_alu_rs1    out  XLEN       (same)
//  rs_to_alu_rs2    out  XLEN       (same)
//  rs_to_alu_rob_index out ROB_WIDTH (same)
//  rs_to_alu_PC     out  XLEN       (same)
//  rs_to_alu_imm    out  XLEN       (same)
// BEHAVIOUR
//  - Reset (rst_in=1 at edge): all entries not busy; all outputs 0. rst_in has priority over clr_in and rdy_in.
//  - rdy_in=0: no state or output changes. rst_in still acts.
//  - clr_in=1 (rdy_in=1): all entries freed; rs_to_alu_ready=0 next cycle; same-cycle issue is discarded.
//  - Entry state: busy, op, vj, qj_pend, qj, vk, qk_pend, qk, rob, pc, imm.
//  - Write: on issue_valid, the lowest-index non-busy entry (judged on pre-edge state) is written.
//    An entry dispatched this cycle is not reused until the next cycle.
//    Issue while rs_full=1 is a protocol violation: the issue is dropped and an assertion fires.
//  - Wakeup, each edge: every busy entry with a pending q equal to a valid broadcast tag captures the value and clears pend.
//    Incoming issue operands also match against same-cycle broadcasts (bypass), so they are never lost.
//    Tag equal on ALU and LSB simultaneously cannot occur; ALU wins if it does.
//  - Select: the lowest-index busy entry with both pend bits clear (pre-edge state) is registered onto rs_to_alu_*.
//    rs_to_alu_ready=1 for exactly one cycle per dispatched entry, and that entry is freed.
//    If nothing is ready, rs_to_alu_ready=0 and the other outputs hold.
//  - Latency: issue at edge t -> earliest rs_to_alu_ready in the cycle after edge t+1.
//    A dependent entry woken by the ALU broadcast of cycle t+1 dispatches after edge t+3.
//  - rs_full: combinational; equals (busy count == RS_SIZE).
//    Not relaxed by a same-cycle dispatch.
// TESTING
//  - Reset: hold rst_in 2 cycles -> rs_full=0, rs_to_alu_ready=0, all outputs 0.
//  - ADDI vj=5, imm=7, rob=3 -> two cycles later rs_to_alu_ready=1, rs1=5, imm=7, rob_index=3.
//    The ALU then reports result 12.
//  - ADD rob=1 (ready), then ADD rob=2 with qj=1 pending:
//    the second dispatches exactly two cycles after the first, with rs1 = first result.
//  - Fill 16 independent entries while all are stalled on LSB tag 9 -> rs_full=1.
//    LSB broadcast tag 9 -> entries dispatch in index order 0..15, one per cycle.
//  - 4 busy entries, assert clr_in with a same-cycle issue -> next cycle all entries free and rs_to_alu_ready=0.
//    No later dispatch occurs.
//  - Issue with qj=6 pending in the same cycle as alu_ready with alu_rob_index=6, alu_result=0xAB -> entry captures 0xAB.
//    The entry dispatches on the normal 2-cycle path.

Source files
------------

// File: rtl/reservation_station.sv
// reservation_station
//   Holds decoded ALU-class instructions until both source operands are
//   available, snoops the ALU and LSB result broadcasts to wake waiting
//   operands, and issues at most one ready entry per cycle to the ALU
//   through a registered rs_to_alu_* bus.
//
// Ports
//   clk_in, rst_in        clock, synchronous active-high reset
//   rdy_in                global enable (low freezes all state)
//   clr_in                flush on misprediction
//   issue_*               dispatch write port (one entry per cycle)
//   rs_full               all entries busy (combinational)
//   alu_*/lsb_*           result broadcast buses (valid, value, tag)
//   rs_to_alu_*           registered issue packet to the ALU
//
// rs_entry
//   One station slot: operand capture on write, tag snoop on the
//   broadcast buses, and release when selected for issue.

module rs_entry #(
    parameter int ROB_WIDTH = 4,
    parameter int OP_WIDTH  = 6,
    parameter int XLEN      = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clr_in,
    input  logic                 wr_en,
    input  logic [OP_WIDTH-1:0]  wr_op,
    input  logic [XLEN-1:0]      wr_vj,
    input  logic                 wr_qj_pend,
    input  logic [ROB_WIDTH-1:0] wr_qj,
    input  logic [XLEN-1:0]      wr_vk,
    input  logic                 wr_qk_pend,
    input  logic [ROB_WIDTH-1:0] wr_qk,
    input  logic [ROB_WIDTH-1:0] wr_rob,
    input  logic [XLEN-1:0]      wr_pc,
    input  logic [XLEN-1:0]      wr_imm,
    input  logic                 free_en,
    input  logic                 alu_ready,
    input  logic [XLEN-1:0]      alu_result,
    input  logic [ROB_WIDTH-1:0] alu_rob_index,
    input  logic                 lsb_ready,
    input  logic [XLEN-1:0]      lsb_result,
    input  logic [ROB_WIDTH-1:0] lsb_rob_index,
    output logic                 busy,
    output logic                 ready,
    output logic [OP_WIDTH-1:0]  op,
    output logic [XLEN-1:0]      vj,
    output logic [XLEN-1:0]      vk,
    output logic [ROB_WIDTH-1:0] rob,
    output logic [XLEN-1:0]      pc,
    output logic [XLEN-1:0]      imm
);
    logic                 qj_pend, qk_pend;
    logic [ROB_WIDTH-1:0] qj, qk;
    logic                 j_alu_hit, j_lsb_hit, k_alu_hit, k_lsb_hit;

    // ALU is checked first so it wins on a (never expected) double match.
    assign j_alu_hit = busy && qj_pend && alu_ready && (alu_rob_index == qj);
    assign j_lsb_hit = busy && qj_pend && lsb_ready && (lsb_rob_index == qj);
    assign k_alu_hit = busy && qk_pend && alu_ready && (alu_rob_index == qk);
    assign k_lsb_hit = busy && qk_pend && lsb_ready && (lsb_rob_index == qk);

    assign ready = busy && !qj_pend && !qk_pend;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy    <= 1'b0;
            op      <= '0;
            vj      <= '0;
            qj_pend <= 1'b0;
            qj      <= '0;
            vk      <= '0;
            qk_pend <= 1'b0;
            qk      <= '0;
            rob     <= '0;
            pc      <= '0;
            imm     <= '0;
        end else if (rdy_in) begin
            if (clr_in) begin
                busy <= 1'b0;
            end else if (wr_en) begin
                // wr_en only reaches a free slot, so no snoop/free conflict.
                busy    <= 1'b1;
                op      <= wr_op;
                vj      <= wr_vj;
                qj_pend <= wr_qj_pend;
                qj      <= wr_qj;
                vk      <= wr_vk;
                qk_pend <= wr_qk_pend;
                qk      <= wr_qk;
                rob     <= wr_rob;
                pc      <= wr_pc;
                imm     <= wr_imm;
            end else begin
                if (free_en) busy <= 1'b0;
                if (j_alu_hit) begin
                    vj      <= alu_result;
                    qj_pend <= 1'b0;
                end else if (j_lsb_hit) begin
                    vj      <= lsb_result;
                    qj_pend <= 1'b0;
                end
                if (k_alu_hit) begin
                    vk      <= alu_result;
                    qk_pend <= 1'b0;
                end else if (k_lsb_hit) begin
                    vk      <= lsb_result;
                    qk_pend <= 1'b0;
                end
            end
        end
    end
endmodule

module reservation_station #(
    parameter int RS_SIZE   = 16,
    parameter int ROB_WIDTH = 4,
    parameter int OP_WIDTH  = 6,
    parameter int XLEN      = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clr_in,
    input  logic                 issue_valid,
    input  logic [OP_WIDTH-1:0]  issue_op,
    input  logic [XLEN-1:0]      issue_vj,
    input  logic [XLEN-1:0]      issue_vk,
    input  logic                 issue_qj_pend,
    input  logic                 issue_qk_pend,
    input  logic [ROB_WIDTH-1:0] issue_qj,
    input  logic [ROB_WIDTH-1:0] issue_qk,
    input  logic [ROB_WIDTH-1:0] issue_rob_index,
    input  logic [XLEN-1:0]      issue_pc,
    input  logic [XLEN-1:0]      issue_imm,
    output logic                 rs_full,
    input  logic                 alu_ready,
    input  logic [XLEN-1:0]      alu_result,
    input  logic [ROB_WIDTH-1:0] alu_rob_index,
    input  logic                 lsb_ready,
    input  logic [XLEN-1:0]      lsb_result,
    input  logic [ROB_WIDTH-1:0] lsb_rob_index,
    output logic                 rs_to_alu_ready,
    output logic [OP_WIDTH-1:0]  rs_to_alu_op,
    output logic [XLEN-1:0]      rs_to_alu_rs1,
    output logic [XLEN-1:0]      rs_to_alu_rs2,
    output logic [ROB_WIDTH-1:0] rs_to_alu_rob_index,
    output logic [XLEN-1:0]      rs_to_alu_PC,
    output logic [XLEN-1:0]      rs_to_alu_imm
);
    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    typedef struct packed {
        logic [XLEN-1:0]      v;
        logic                 pend;
        logic [ROB_WIDTH-1:0] q;
    } opnd_t;

    typedef struct packed {
        logic                 vld;
        logic [OP_WIDTH-1:0]  op;
        logic [XLEN-1:0]      rs1;
        logic [XLEN-1:0]      rs2;
        logic [ROB_WIDTH-1:0] rob;
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      imm;
    } alu_req_t;

    logic [RS_SIZE-1:0]                ent_busy, ent_ready;
    logic [RS_SIZE-1:0][OP_WIDTH-1:0]  ent_op;
    logic [RS_SIZE-1:0][XLEN-1:0]      ent_vj, ent_vk, ent_pc, ent_imm;
    logic [RS_SIZE-1:0][ROB_WIDTH-1:0] ent_rob;

    logic [RS_SIZE-1:0] free_oh, wr_oh, sel_oh;
    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    opnd_t              in_j, in_k;
    alu_req_t           out_q;

    // Same-cycle broadcast bypass on the incoming operands so a result
    // that lands while the instruction is being written is not missed.
    function automatic opnd_t snoop(input logic [XLEN-1:0] v, input logic pend,
                                    input logic [ROB_WIDTH-1:0] q);
        opnd_t r;
        r.v    = v;
        r.pend = pend;
        r.q    = q;
        if (pend && alu_ready && (alu_rob_index == q)) begin
            r.v    = alu_result;
            r.pend = 1'b0;
        end else if (pend && lsb_ready && (lsb_rob_index == q)) begin
            r.v    = lsb_result;
            r.pend = 1'b0;
        end
        return r;
    endfunction

    always_comb begin
        in_j = snoop(issue_vj, issue_qj_pend, issue_qj);
        in_k = snoop(issue_vk, issue_qk_pend, issue_qk);
    end

    // Lowest-index free and lowest-index ready slots, both on pre-edge state.
    always_comb begin
        free_oh   = '0;
        sel_oh    = '0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!ent_busy[i]) begin
                free_oh    = '0;
                free_oh[i] = 1'b1;
            end
            if (ent_ready[i]) begin
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    // When full, free_oh is zero and the write falls on the floor.
    assign wr_oh   = issue_valid ? free_oh : '0;
    assign rs_full = &ent_busy;

    for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_ent
        rs_entry #(
            .ROB_WIDTH(ROB_WIDTH),
            .OP_WIDTH (OP_WIDTH),
            .XLEN     (XLEN)
        ) u_ent (
            .clk_in       (clk_in),
            .rst_in       (rst_in),
            .rdy_in       (rdy_in),
            .clr_in       (clr_in),
            .wr_en        (wr_oh[gi]),
            .wr_op        (issue_op),
            .wr_vj        (in_j.v),
            .wr_qj_pend   (in_j.pend),
            .wr_qj        (in_j.q),
            .wr_vk        (in_k.v),
            .wr_qk_pend   (in_k.pend),
            .wr_qk        (in_k.q),
            .wr_rob       (issue_rob_index),
            .wr_pc        (issue_pc),
            .wr_imm       (issue_imm),
            .free_en      (sel_oh[gi]),
            .alu_ready    (alu_ready),
            .alu_result   (alu_result),
            .alu_rob_index(alu_rob_index),
            .lsb_ready    (lsb_ready),
            .lsb_result   (lsb_result),
            .lsb_rob_index(lsb_rob_index),
            .busy         (ent_busy[gi]),
            .ready        (ent_ready[gi]),
            .op           (ent_op[gi]),
            .vj           (ent_vj[gi]),
            .vk           (ent_vk[gi]),
            .rob          (ent_rob[gi]),
            .pc           (ent_pc[gi]),
            .imm          (ent_imm[gi])
        );
    end

    // Issue register; payload holds when nothing is selected.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            out_q <= '0;
        end else if (rdy_in) begin
            if (clr_in) begin
                out_q.vld <= 1'b0;
            end else if (sel_found) begin
                out_q.vld <= 1'b1;
                out_q.op  <= ent_op[sel_idx];
                out_q.rs1 <= ent_vj[sel_idx];
                out_q.rs2 <= ent_vk[sel_idx];
                out_q.rob <= ent_rob[sel_idx];
                out_q.pc  <= ent_pc[sel_idx];
                out_q.imm <= ent_imm[sel_idx];
            end else begin
                out_q.vld <= 1'b0;
            end
        end
    end

    assign rs_to_alu_ready     = out_q.vld;
    assign rs_to_alu_op        = out_q.op;
    assign rs_to_alu_rs1       = out_q.rs1;
    assign rs_to_alu_rs2       = out_q.rs2;
    assign rs_to_alu_rob_index = out_q.rob;
    assign rs_to_alu_PC        = out_q.pc;
    assign rs_to_alu_imm       = out_q.imm;

    // The dispatcher must honour rs_full.
    a_no_issue_when_full: assert property (
        @(posedge clk_in) disable iff (rst_in)
        (rdy_in && !clr_in && issue_valid) |-> !rs_full
    );
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station
//   Directed bench for reservation_station: reset, single issue, dependent
//   wakeup through the ALU bus, fill to full with an LSB-driven release,
//   flush, same-cycle bypass and the rdy_in freeze.

module tb_reservation_station;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        clr_in = 1'b0;
    logic        issue_valid = 1'b0;
    logic [5:0]  issue_op = '0;
    logic [31:0] issue_vj = '0, issue_vk = '0, issue_pc = '0, issue_imm = '0;
    logic        issue_qj_pend = 1'b0, issue_qk_pend = 1'b0;
    logic [3:0]  issue_qj = '0, issue_qk = '0, issue_rob_index = '0;
    logic        rs_full;
    logic        alu_ready = 1'b0, lsb_ready = 1'b0;
    logic [31:0] alu_result = '0, lsb_result = '0;
    logic [3:0]  alu_rob_index = '0, lsb_rob_index = '0;
    logic        rs_to_alu_ready;
    logic [5:0]  rs_to_alu_op;
    logic [31:0] rs_to_alu_rs1, rs_to_alu_rs2, rs_to_alu_PC, rs_to_alu_imm;
    logic [3:0]  rs_to_alu_rob_index;

    int errors = 0;
    int checks = 0;

    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_ADDI = 6'd2;

    reservation_station dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
        .issue_valid(issue_valid), .issue_op(issue_op),
        .issue_vj(issue_vj), .issue_vk(issue_vk),
        .issue_qj_pend(issue_qj_pend), .issue_qk_pend(issue_qk_pend),
        .issue_qj(issue_qj), .issue_qk(issue_qk),
        .issue_rob_index(issue_rob_index), .issue_pc(issue_pc), .issue_imm(issue_imm),
        .rs_full(rs_full),
        .alu_ready(alu_ready), .alu_result(alu_result), .alu_rob_index(alu_rob_index),
        .lsb_ready(lsb_ready), .lsb_result(lsb_result), .lsb_rob_index(lsb_rob_index),
        .rs_to_alu_ready(rs_to_alu_ready), .rs_to_alu_op(rs_to_alu_op),
        .rs_to_alu_rs1(rs_to_alu_rs1), .rs_to_alu_rs2(rs_to_alu_rs2),
        .rs_to_alu_rob_index(rs_to_alu_rob_index), .rs_to_alu_PC(rs_to_alu_PC),
        .rs_to_alu_imm(rs_to_alu_imm)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [5:0] op, input logic [31:0] vj, input logic qjp,
                       input logic [3:0] qj, input logic [31:0] vk, input logic qkp,
                       input logic [3:0] qk, input logic [3:0] rob,
                       input logic [31:0] pc, input logic [31:0] imm);
        issue_valid     = 1'b1;
        issue_op        = op;
        issue_vj        = vj;
        issue_qj_pend   = qjp;
        issue_qj        = qj;
        issue_vk        = vk;
        issue_qk_pend   = qkp;
        issue_qk        = qk;
        issue_rob_index = rob;
        issue_pc        = pc;
        issue_imm       = imm;
    endtask

    initial begin
        // Reset held two cycles
        step();
        step();
        chk("rst_full", 32'(rs_full), 32'd0);
        chk("rst_ready", 32'(rs_to_alu_ready), 32'd0);
        chk("rst_op", 32'(rs_to_alu_op), 32'd0);
        chk("rst_rs1", rs_to_alu_rs1, 32'd0);
        chk("rst_rs2", rs_to_alu_rs2, 32'd0);
        chk("rst_rob", 32'(rs_to_alu_rob_index), 32'd0);
        chk("rst_pc", rs_to_alu_PC, 32'd0);
        chk("rst_imm", rs_to_alu_imm, 32'd0);
        rst_in = 1'b0;

        // ADDI vj=5 imm=7 rob=3
        put(OP_ADDI, 32'd5, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd3, 32'h100, 32'd7);
        step();
        issue_valid = 1'b0;
        chk("addi_early", 32'(rs_to_alu_ready), 32'd0);
        step();
        chk("addi_ready", 32'(rs_to_alu_ready), 32'd1);
        chk("addi_op", 32'(rs_to_alu_op), 32'(OP_ADDI));
        chk("addi_rs1", rs_to_alu_rs1, 32'd5);
        chk("addi_imm", rs_to_alu_imm, 32'd7);
        chk("addi_rob", 32'(rs_to_alu_rob_index), 32'd3);
        chk("addi_pc", rs_to_alu_PC, 32'h100);
        chk("addi_alu_sum", rs_to_alu_rs1 + rs_to_alu_imm, 32'd12);
        step();
        chk("addi_one_shot", 32'(rs_to_alu_ready), 32'd0);
        chk("addi_hold_rs1", rs_to_alu_rs1, 32'd5);

        // ADD rob=1 ready, then ADD rob=2 waiting on tag 1
        put(OP_ADD, 32'd10, 1'b0, 4'd0, 32'd20, 1'b0, 4'd0, 4'd1, 32'h200, 32'd0);
        step();
        put(OP_ADD, 32'd0, 1'b1, 4'd1, 32'd3, 1'b0, 4'd0, 4'd2, 32'h204, 32'd0);
        step();
        issue_valid = 1'b0;
        chk("dep1_ready", 32'(rs_to_alu_ready), 32'd1);
        chk("dep1_rob", 32'(rs_to_alu_rob_index), 32'd1);
        chk("dep1_rs2", rs_to_alu_rs2, 32'd20);
        alu_ready     = 1'b1;
        alu_rob_index = 4'd1;
        alu_result    = 32'd30;
        step();
        alu_ready = 1'b0;
        chk("dep_gap", 32'(rs_to_alu_ready), 32'd0);
        step();
        chk("dep2_ready", 32'(rs_to_alu_ready), 32'd1);
        chk("dep2_rob", 32'(rs_to_alu_rob_index), 32'd2);
        chk("dep2_rs1", rs_to_alu_rs1, 32'd30);
        chk("dep2_rs2", rs_to_alu_rs2, 32'd3);
        step();
        chk("dep_idle", 32'(rs_to_alu_ready), 32'd0);

        // Fill all 16 slots, each waiting on LSB tag 9
        for (int i = 0; i < 16; i++) begin
            chk("fill_not_full", 32'(rs_full), 32'd0);
            put(OP_ADD, 32'd0, 1'b1, 4'd9, 32'(i), 1'b0, 4'd0, 4'(i), 32'(i * 4), 32'd0);
            step();
            chk("fill_no_issue", 32'(rs_to_alu_ready), 32'd0);
        end
        issue_valid = 1'b0;
        chk("fill_full", 32'(rs_full), 32'd1);
        lsb_ready     = 1'b1;
        lsb_rob_index = 4'd9;
        lsb_result    = 32'h55;
        step();
        lsb_ready = 1'b0;
        chk("wake_no_issue", 32'(rs_to_alu_ready), 32'd0);
        chk("wake_still_full", 32'(rs_full), 32'd1);
        for (int i = 0; i < 16; i++) begin
            step();
            chk("drain_ready", 32'(rs_to_alu_ready), 32'd1);
            chk("drain_rob", 32'(rs_to_alu_rob_index), 32'(i));
            chk("drain_rs1", rs_to_alu_rs1, 32'h55);
            chk("drain_rs2", rs_to_alu_rs2, 32'(i));
            if (i == 0) chk("drain_not_full", 32'(rs_full), 32'd0);
        end
        step();
        chk("drain_done", 32'(rs_to_alu_ready), 32'd0);

        // Four waiting entries, then flush with a same-cycle issue
        for (int i = 0; i < 4; i++) begin
            put(OP_ADD, 32'd0, 1'b1, 4'd10, 32'd0, 1'b0, 4'd0, 4'(4 + i), 32'd0, 32'd0);
            step();
        end
        put(OP_ADDI, 32'd1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd8, 32'd0, 32'd1);
        clr_in = 1'b1;
        step();
        clr_in      = 1'b0;
        issue_valid = 1'b0;
        chk("clr_ready", 32'(rs_to_alu_ready), 32'd0);
        chk("clr_full", 32'(rs_full), 32'd0);
        alu_ready     = 1'b1;
        alu_rob_index = 4'd10;
        alu_result    = 32'h77;
        step();
        alu_ready = 1'b0;
        chk("clr_dead0", 32'(rs_to_alu_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("clr_dead", 32'(rs_to_alu_ready), 32'd0);
        end

        // Same-cycle bypass: qj via ALU tag 6, qk via LSB tag 3
        put(OP_ADD, 32'd0, 1'b1, 4'd6, 32'd0, 1'b1, 4'd3, 4'd5, 32'h300, 32'd0);
        alu_ready     = 1'b1;
        alu_rob_index = 4'd6;
        alu_result    = 32'hAB;
        lsb_ready     = 1'b1;
        lsb_rob_index = 4'd3;
        lsb_result    = 32'h66;
        step();
        issue_valid = 1'b0;
        alu_ready   = 1'b0;
        lsb_ready   = 1'b0;
        chk("byp_early", 32'(rs_to_alu_ready), 32'd0);
        step();
        chk("byp_ready", 32'(rs_to_alu_ready), 32'd1);
        chk("byp_rs1", rs_to_alu_rs1, 32'hAB);
        chk("byp_rs2", rs_to_alu_rs2, 32'h66);
        chk("byp_rob", 32'(rs_to_alu_rob_index), 32'd5);
        step();

        // rdy_in low: issue is ignored
        rdy_in = 1'b0;
        put(OP_ADDI, 32'd9, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd11, 32'd0, 32'd0);
        step();
        issue_valid = 1'b0;
        step();
        chk("frz_ready", 32'(rs_to_alu_ready), 32'd0);
        chk("frz_hold", rs_to_alu_rs1, 32'hAB);
        rdy_in = 1'b1;
        step();
        step();
        chk("frz_dropped", 32'(rs_to_alu_ready), 32'd0);

        // rdy_in low with a ready entry: dispatch waits for rdy_in
        put(OP_ADDI, 32'd4, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd12, 32'd0, 32'd0);
        step();
        issue_valid = 1'b0;
        rdy_in      = 1'b0;
        step();
        step();
        chk("frz_wait", 32'(rs_to_alu_ready), 32'd0);
        rdy_in = 1'b1;
        step();
        chk("frz_go", 32'(rs_to_alu_ready), 32'd1);
        chk("frz_rob", 32'(rs_to_alu_rob_index), 32'd12);
        chk("frz_rs1", rs_to_alu_rs1, 32'd4);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
